alu_share_arbiter: RTL and testbench

- Shares one combinational `alu` instance between NUM_REQ issue lanes of the superscalar core.
- Each lane has its own valid/ready request port. One request is granted per cycle, using round-robin priority.
- The ALU result is captured in a single output register, which is returned on one response port tagged with the source lane.
- Sits between the issue stage and writeback. It is the only path to the shared bit-manipulation ops (CTZ/CLZ/CPOP).

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 49 ++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/alu_share_arbiter.sv | 105 ++++++++++
 tb/tb_alu_share_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, legality helper and lane payload type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_CTZ  = 4'b1001;
  localparam logic [3:0] ALU_CLZ  = 4'b1010;
  localparam logic [3:0] ALU_CPOP = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } alu_req_t;

  function automatic logic is_legal_alu_op(input logic [3:0] op);
    case (op)
      4'b1100, 4'b1110, 4'b1111: return 1'b0;
      default:                   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU including the CTZ/CLZ/CPOP bit-manipulation ops.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result
);

  logic [5:0] ctz_s;
  logic [5:0] clz_s;
  logic [5:0] cpop_s;

  // Bit counts; a zero operand leaves CTZ/CLZ at 32.
  always_comb begin
    ctz_s  = 6'd32;
    clz_s  = 6'd32;
    cpop_s = 6'd0;
    for (int i = 31; i >= 0; i--) begin
      ctz_s = a[i] ? 6'(i) : ctz_s;
    end
    for (int i = 0; i < 32; i++) begin
      clz_s  = a[i] ? 6'(31 - i) : clz_s;
      cpop_s = cpop_s + {5'd0, a[i]};
    end
  end

  // Opcode decode; undefined opcodes yield zero.
  always_comb begin
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_SUB:  result = a - b;
      ALU_CTZ:  result = {26'd0, ctz_s};
      ALU_CLZ:  result = {26'd0, clz_s};
      ALU_CPOP: result = {26'd0, cpop_s};
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap) wins.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic             enable,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic found_s;
  int   cand_s;

  // Linear search starting from the pointer lane.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int k = 0; k < N; k++) begin
      cand_s = (int'(ptr) + k) % N;
      if (enable && !found_s && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        idx           = IDX_W'(cand_s);
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ issue lanes with round-robin grant and a
// single registered, lane-tagged response slot.
module alu_share_arbiter #(
  parameter  int NUM_REQ = 2,
  parameter  int TAG_W   = 6,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_a,
  input  logic [NUM_REQ*32-1:0]    req_b,
  input  logic [NUM_REQ*4-1:0]     req_op,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_result,
  output logic [SRC_W-1:0]         resp_src,
  output logic [TAG_W-1:0]         resp_tag,
  output logic                     resp_illegal
);
  import alu_pkg::*;

  logic [SRC_W-1:0]   ptr_r;
  logic [SRC_W-1:0]   ptr_next_s;
  logic               resp_valid_r;
  logic [31:0]        resp_result_r;
  logic [SRC_W-1:0]   resp_src_r;
  logic [TAG_W-1:0]   resp_tag_r;
  logic               resp_illegal_r;
  logic               slot_free_s;
  logic               grant_en_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [SRC_W-1:0]   gidx_s;
  logic               fire_s;
  alu_req_t           sel_req_s;
  logic [TAG_W-1:0]   sel_tag_s;
  logic [31:0]        alu_result_s;

  assign slot_free_s = !resp_valid_r || resp_ready;
  assign grant_en_s  = rst_n && !flush && slot_free_s;
  assign fire_s      = |(grant_s & req_valid);
  assign req_ready   = grant_s;
  assign ptr_next_s  = (gidx_s == SRC_W'(NUM_REQ - 1)) ? '0 : gidx_s + SRC_W'(1);

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_rr (
    .req    (req_valid),
    .enable (grant_en_s),
    .ptr    (ptr_r),
    .grant  (grant_s),
    .idx    (gidx_s)
  );

  // Operand mux feeding the single ALU from the granted lane.
  always_comb begin
    sel_req_s.a  = req_a[32*int'(gidx_s) +: 32];
    sel_req_s.b  = req_b[32*int'(gidx_s) +: 32];
    sel_req_s.op = req_op[4*int'(gidx_s) +: 4];
    sel_tag_s    = req_tag[TAG_W*int'(gidx_s) +: TAG_W];
  end

  alu u_alu (
    .a      (sel_req_s.a),
    .b      (sel_req_s.b),
    .op     (sel_req_s.op),
    .result (alu_result_s)
  );

  // Response slot and RR pointer; flush drops the slot without granting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r          <= '0;
      resp_valid_r   <= 1'b0;
      resp_result_r  <= 32'd0;
      resp_src_r     <= '0;
      resp_tag_r     <= '0;
      resp_illegal_r <= 1'b0;
    end else if (flush) begin
      resp_valid_r   <= 1'b0;
    end else if (fire_s) begin
      ptr_r          <= ptr_next_s;
      resp_valid_r   <= 1'b1;
      resp_result_r  <= alu_result_s;
      resp_src_r     <= gidx_s;
      resp_tag_r     <= sel_tag_s;
      resp_illegal_r <= !is_legal_alu_op(sel_req_s.op);
    end else if (resp_ready) begin
      resp_valid_r   <= 1'b0;
    end else begin
      resp_valid_r   <= resp_valid_r;
    end
  end

  assign resp_valid   = resp_valid_r;
  assign resp_result  = resp_result_r;
  assign resp_src     = resp_src_r;
  assign resp_tag     = resp_tag_r;
  assign resp_illegal = resp_illegal_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: 2-lane instance for the main plan, 4-lane instance for wrap-around.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // 2-lane instance signals
  logic        flush2, resp_ready2;
  logic [1:0]  valid2, ready2;
  logic [63:0] a2, b2;
  logic [7:0]  op2;
  logic [11:0] tag2;
  logic        rv2, ill2;
  logic [31:0] res2;
  logic [0:0]  src2;
  logic [5:0]  rtag2;

  // 4-lane instance signals
  logic         flush4, resp_ready4;
  logic [3:0]   valid4, ready4;
  logic [127:0] a4, b4;
  logic [15:0]  op4;
  logic [23:0]  tag4;
  logic         rv4, ill4;
  logic [31:0]  res4;
  logic [1:0]   src4;
  logic [5:0]   rtag4;

  alu_share_arbiter #(.NUM_REQ(2), .TAG_W(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .req_valid(valid2), .req_ready(ready2),
    .req_a(a2), .req_b(b2), .req_op(op2), .req_tag(tag2),
    .resp_valid(rv2), .resp_ready(resp_ready2), .resp_result(res2),
    .resp_src(src2), .resp_tag(rtag2), .resp_illegal(ill2)
  );

  alu_share_arbiter #(.NUM_REQ(4), .TAG_W(6)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4), .req_valid(valid4), .req_ready(ready4),
    .req_a(a4), .req_b(b4), .req_op(op4), .req_tag(tag4),
    .resp_valid(rv4), .resp_ready(resp_ready4), .resp_result(res4),
    .resp_src(src4), .resp_tag(rtag4), .resp_illegal(ill4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set2(input int l, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] tg);
    a2[32*l +: 32] = a;
    b2[32*l +: 32] = b;
    op2[4*l +: 4]  = op;
    tag2[6*l +: 6] = tg;
  endtask

  task automatic set4(input int l, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] tg);
    a4[32*l +: 32] = a;
    b4[32*l +: 32] = b;
    op4[4*l +: 4]  = op;
    tag4[6*l +: 6] = tg;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'b1001, 32'h0000_0000, 32'h0,  32'd32,        1'b0}; // CTZ 0
    vecs[1] = '{4'b1010, 32'h0001_0000, 32'h0,  32'd15,        1'b0}; // CLZ
    vecs[2] = '{4'b1101, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0}; // SRA
    vecs[3] = '{4'b1110, 32'd123,       32'd45, 32'd0,         1'b1}; // illegal
    vecs[4] = '{4'b0010, 32'hFFFF_FFFF, 32'd1,  32'd1,         1'b0}; // SLT -1<1
    vecs[5] = '{4'b0011, 32'hFFFF_FFFF, 32'd1,  32'd0,         1'b0}; // SLTU
    vecs[6] = '{4'b0001, 32'd1,         32'h24, 32'h10,        1'b0}; // SLL by 4

    rst_n = 1'b0;
    flush2 = 1'b0; resp_ready2 = 1'b1; valid2 = 2'b11;
    a2 = '0; b2 = '0; op2 = '0; tag2 = '0;
    set2(0, 4'b0000, 32'd5, 32'd7, 6'h11);
    set2(1, 4'b1000, 32'd5, 32'd7, 6'h22);
    flush4 = 1'b0; resp_ready4 = 1'b1; valid4 = 4'b0000;
    a4 = '0; b4 = '0; op4 = '0; tag4 = '0;

    // Reset held for 3 cycles with all lanes requesting
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_ready", {62'd0, ready2}, 64'd0);
      check_eq("rst_valid", {63'd0, rv2}, 64'd0);
    end
    check_eq("rst_result", {32'd0, res2}, 64'd0);
    check_eq("rst_tag", {58'd0, rtag2}, 64'd0);
    check_eq("rst_ill", {63'd0, ill2}, 64'd0);

    // Release: lane 0 first, then strict alternation at 1 op/cycle
    rst_n = 1'b1;
    settle();
    check_eq("rel_ready", {62'd0, ready2}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("rr_valid", {63'd0, rv2}, 64'd1);
      check_eq("rr_src", {63'd0, src2}, (i % 2 == 1) ? 64'd1 : 64'd0);
      check_eq("rr_result", {32'd0, res2}, (i % 2 == 1) ? 64'hFFFF_FFFE : 64'd12);
      check_eq("rr_tag", {58'd0, rtag2}, (i % 2 == 1) ? 64'h22 : 64'h11);
      settle();
      check_eq("rr_ready", {62'd0, ready2}, (i % 2 == 1) ? 64'd1 : 64'd2);
    end

    // Backpressure: CPOP result held while consumer stalls
    valid2 = 2'b01;
    set2(0, 4'b1011, 32'hF0F0_0001, 32'd0, 6'h01);
    settle();
    check_eq("bp_ready0", {62'd0, ready2}, 64'd1);
    tick();
    resp_ready2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("bp_valid", {63'd0, rv2}, 64'd1);
      check_eq("bp_result", {32'd0, res2}, 64'd9);
      check_eq("bp_ready", {62'd0, ready2}, 64'd0);
      tick();
    end
    resp_ready2 = 1'b1;
    settle();
    check_eq("bp_release_ready", {62'd0, ready2}, 64'd1);
    tick();
    check_eq("bp_next_valid", {63'd0, rv2}, 64'd1);
    check_eq("bp_next_src", {63'd0, src2}, 64'd0);

    // Bit-manipulation edges and illegal opcode through lane 0
    for (int i = 0; i < 7; i++) begin
      set2(0, vecs[i].op, vecs[i].a, vecs[i].b, 6'(i));
      tick();
      check_eq("vec_result", {32'd0, res2}, {32'd0, vecs[i].exp});
      check_eq("vec_illegal", {63'd0, ill2}, {63'd0, vecs[i].ill});
      check_eq("vec_tag", {58'd0, rtag2}, 64'(i));
    end

    // Flush with a stalled response and lane 1 waiting
    set2(0, 4'b0000, 32'd1, 32'd2, 6'h05);
    tick();
    check_eq("fl_pre_result", {32'd0, res2}, 64'd3);
    valid2 = 2'b11;
    resp_ready2 = 1'b0;
    flush2 = 1'b1;
    settle();
    check_eq("fl_ready", {62'd0, ready2}, 64'd0);
    tick();
    check_eq("fl_valid", {63'd0, rv2}, 64'd0);
    flush2 = 1'b0;
    settle();
    check_eq("fl_after_ready", {62'd0, ready2}, 64'd2);
    tick();
    check_eq("fl_after_valid", {63'd0, rv2}, 64'd1);
    check_eq("fl_after_src", {63'd0, src2}, 64'd1);
    check_eq("fl_after_result", {32'd0, res2}, 64'hFFFF_FFFE);
    check_eq("fl_after_tag", {58'd0, rtag2}, 64'h22);
    valid2 = 2'b00;
    resp_ready2 = 1'b1;
    tick();
    check_eq("retire_valid", {63'd0, rv2}, 64'd0);
    check_eq("retire_hold", {32'd0, res2}, 64'hFFFF_FFFE);

    // 4-lane wrap: move pointer to 3, then lanes 3 and 0 compete
    valid4 = 4'b0100;
    set4(2, 4'b0000, 32'd1, 32'd1, 6'h02);
    tick();
    check_eq("w4_lane2_src", {62'd0, src4}, 64'd2);
    valid4 = 4'b1001;
    set4(3, 4'b0000, 32'd3, 32'd4, 6'h33);
    set4(0, 4'b0100, 32'hFF, 32'h0F, 6'h0A);
    settle();
    check_eq("w4_ready0", {60'd0, ready4}, 64'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("w4_valid", {63'd0, rv4}, 64'd1);
      check_eq("w4_src", {62'd0, src4}, (i % 2 == 0) ? 64'd3 : 64'd0);
      check_eq("w4_tag", {58'd0, rtag4}, (i % 2 == 0) ? 64'h33 : 64'h0A);
      check_eq("w4_result", {32'd0, res4}, (i % 2 == 0) ? 64'd7 : 64'hF0);
      check_eq("w4_ill", {63'd0, ill4}, 64'd0);
      settle();
      check_eq("w4_ready", {60'd0, ready4}, (i % 2 == 0) ? 64'h1 : 64'h8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
